// File: rtl/cache_pkg.sv
// Shared encodings for the cache write path: tag-array status/commands,
// channel progress codes, fetch commands and the write-buffer FSM states.
package cache_pkg;

  localparam logic [2:0] AST_MISS      = 3'b000;
  localparam logic [2:0] AST_HIT_CLEAN = 3'b001;
  localparam logic [2:0] AST_HIT_DIRTY = 3'b010;
  localparam logic [2:0] AST_IN_FLIGHT = 3'b100;

  localparam logic [2:0] PS_IDLE  = 3'b000;
  localparam logic [2:0] PS_CHECK = 3'b001;
  localparam logic [2:0] PS_BUSY  = 3'b010;
  localparam logic [2:0] PS_DONE  = 3'b011;
  localparam logic [2:0] PS_WAIT  = 3'b100;

  localparam logic [1:0] CMD_LOOKUP = 2'b00;
  localparam logic [1:0] CMD_ALLOC  = 2'b10;
  localparam logic [1:0] CMD_DIRTY  = 2'b11;

  localparam logic [1:0] FC_FETCH    = 2'b01;
  localparam logic [1:0] FC_WB_FETCH = 2'b10;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOOKUP,
    S_CHECK_CONFLICT,
    S_WAIT_CONFLICT,
    S_ALLOCATE,
    S_FETCH_REQ,
    S_WAIT_FETCH,
    S_WRITE_MEM,
    S_DONE
  } wb_state_e;

  // The allocator reports victim state; a clean/absent victim means a plain fetch.
  function automatic logic [1:0] alloc_fetch_cmd(input logic [1:0] victim_st);
    return (victim_st == 2'b00) ? FC_FETCH : victim_st;
  endfunction

endpackage

// File: rtl/wr_merge_fifo.sv
// Write-buffer FIFO of {addr, data, strb} entries with in-place merge into the tail.
module wr_merge_fifo
  import cache_pkg::*;
#(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int DEPTH = 4,
  parameter int BB    = 2,
  localparam int SW   = DW / 8,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          merge,
  input  logic          pop,
  input  logic [AW-1:0] push_addr,
  input  logic [DW-1:0] push_data,
  input  logic [SW-1:0] push_strb,
  input  logic [AW-1:0] cmp_addr,
  output logic          tail_match,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic [AW-1:0] head_addr,
  output logic [DW-1:0] head_data,
  output logic [SW-1:0] head_strb
);

  localparam logic [AW-1:0] WORD_MASK = {AW{1'b1}} << BB;

  logic [AW-1:0] addr_q [DEPTH];
  logic [AW-1:0] addr_d [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [DW-1:0] data_d [DEPTH];
  logic [SW-1:0] strb_q [DEPTH];
  logic [SW-1:0] strb_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, tail_ptr;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_merge, do_pop;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign count     = count_q;
  assign tail_ptr  = wr_ptr_q - PW'(1);
  assign head_addr = empty ? '0 : addr_q[rd_ptr_q];
  assign head_data = empty ? '0 : data_q[rd_ptr_q];
  assign head_strb = empty ? '0 : strb_q[rd_ptr_q];
  assign tail_match = !empty && (((addr_q[tail_ptr] ^ cmp_addr) & WORD_MASK) == '0);

  always_comb begin
    do_push  = push && !merge && !full;
    do_merge = push && merge && !empty;
    do_pop   = pop && !empty;
    addr_d   = addr_q;
    data_d   = data_q;
    strb_d   = strb_q;
    if (do_merge) begin
      for (int b = 0; b < SW; b++) begin
        if (push_strb[b]) data_d[tail_ptr][8*b +: 8] = push_data[8*b +: 8];
      end
      strb_d[tail_ptr] = strb_q[tail_ptr] | push_strb;
    end
    if (do_push) begin
      addr_d[wr_ptr_q] = push_addr;
      data_d[wr_ptr_q] = push_data;
      strb_d[wr_ptr_q] = push_strb;
    end
    wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  // Entry storage is never read while empty, so it carries no reset.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
    strb_q <= strb_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/wr_buf_ctrl.sv
// Write-buffer controller: buffers/merges writes, resolves each head line through
// lookup, conflict check, allocate and fetch, then writes the data array.
module wr_buf_ctrl
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LIST_DEPTH = 4,
  parameter int LIST_WIDTH = 32,
  parameter int WB_DEPTH   = 4,
  parameter int MERGE_EN   = 1,
  localparam int TW = $clog2(LIST_DEPTH),
  localparam int WW = $clog2(LIST_WIDTH),
  localparam int SW = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  acc_wr_valid,
  output logic                  acc_wr_ready,
  input  logic [ADDR_WIDTH-1:0] acc_wr_addr,
  input  logic [DATA_WIDTH-1:0] acc_wr_data,
  input  logic [SW-1:0]         acc_wr_strb,
  output logic                  acc_req,
  output logic [1:0]            acc_cmd,
  output logic [ADDR_WIDTH-1:0] acc_index,
  input  logic [2:0]            acc_status,
  input  logic [TW-1:0]         return_tag,
  input  logic                  allocate_busy,
  output logic [2:0]            proc_status_w,
  output logic [ADDR_WIDTH-1:0] proc_addr_w,
  input  logic [2:0]            proc_status_r,
  input  logic [ADDR_WIDTH-1:0] proc_addr_r,
  output logic                  fetch_req,
  input  logic                  fetch_gnt,
  input  logic                  fetch_done,
  output logic [1:0]            fetch_cmd,
  output logic [TW-1:0]         fetch_tag,
  output logic [ADDR_WIDTH-1:0] fetch_addr,
  output logic                  mem_wen,
  output logic [TW+WW-1:0]      mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [SW-1:0]         mem_wstrb,
  input  logic                  mem_wready,
  output logic                  wb_empty
);

  localparam int OW = $clog2(LIST_WIDTH * SW);
  localparam int BB = $clog2(SW);
  localparam int CW = $clog2(WB_DEPTH) + 1;
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = {ADDR_WIDTH{1'b1}} << OW;

  wb_state_e             state_q, state_d;
  logic [TW-1:0]         tag_q, tag_d;
  logic [1:0]            fcmd_q, fcmd_d;
  logic                  push, pop, merge_hit, tail_match, full, empty;
  logic [CW-1:0]         count;
  logic [ADDR_WIDTH-1:0] head_addr, head_line;
  logic [DATA_WIDTH-1:0] head_data;
  logic [SW-1:0]         head_strb;

  wr_merge_fifo #(
    .AW    (ADDR_WIDTH),
    .DW    (DATA_WIDTH),
    .DEPTH (WB_DEPTH),
    .BB    (BB)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .merge      (merge_hit),
    .pop        (pop),
    .push_addr  (acc_wr_addr),
    .push_data  (acc_wr_data),
    .push_strb  (acc_wr_strb),
    .cmp_addr   (acc_wr_addr),
    .tail_match (tail_match),
    .full       (full),
    .empty      (empty),
    .count      (count),
    .head_addr  (head_addr),
    .head_data  (head_data),
    .head_strb  (head_strb)
  );

  // A lone entry may only be merged before the FSM starts draining it.
  assign merge_hit    = (MERGE_EN != 0) && tail_match &&
                        ((count >= CW'(2)) || ((count == CW'(1)) && (state_q == S_IDLE)));
  assign acc_wr_ready = !full || merge_hit;
  assign push         = acc_wr_valid && acc_wr_ready;

  assign head_line   = head_addr & LINE_MASK;
  assign acc_index   = head_line;
  assign proc_addr_w = head_line;
  assign fetch_addr  = head_line;
  assign fetch_tag   = tag_q;
  assign fetch_cmd   = fcmd_q;
  assign mem_waddr   = mem_wen ? {tag_q, head_addr[OW-1:BB]} : '0;
  assign mem_wdata   = mem_wen ? head_data : '0;
  assign mem_wstrb   = mem_wen ? head_strb : '0;
  assign wb_empty    = empty && (state_q == S_IDLE);

  always_comb begin
    state_d       = state_q;
    tag_d         = tag_q;
    fcmd_d        = fcmd_q;
    acc_req       = 1'b0;
    acc_cmd       = CMD_LOOKUP;
    fetch_req     = 1'b0;
    mem_wen       = 1'b0;
    pop           = 1'b0;
    proc_status_w = PS_IDLE;
    case (state_q)
      S_IDLE: if (!empty) state_d = S_LOOKUP;
      S_LOOKUP: begin
        acc_req = 1'b1;
        if (acc_status == AST_HIT_CLEAN || acc_status == AST_HIT_DIRTY) begin
          tag_d   = return_tag;
          state_d = S_WRITE_MEM;
        end else if (acc_status == AST_IN_FLIGHT) begin
          state_d = S_WAIT_CONFLICT;
        end else if (acc_status == AST_MISS) begin
          state_d = S_CHECK_CONFLICT;
        end
      end
      S_CHECK_CONFLICT: begin
        proc_status_w = PS_CHECK;
        if (proc_status_r == PS_BUSY && proc_addr_r == head_line) state_d = S_WAIT_CONFLICT;
        else                                                     state_d = S_ALLOCATE;
      end
      S_WAIT_CONFLICT: begin
        proc_status_w = PS_WAIT;
        if (proc_status_r != PS_BUSY && proc_status_r != PS_WAIT) state_d = S_LOOKUP;
      end
      S_ALLOCATE: begin
        proc_status_w = PS_BUSY;
        if (!allocate_busy) begin
          acc_req = 1'b1;
          acc_cmd = CMD_ALLOC;
          tag_d   = return_tag;
          fcmd_d  = alloc_fetch_cmd(acc_status[1:0]);
          state_d = S_FETCH_REQ;
        end
      end
      S_FETCH_REQ: begin
        proc_status_w = PS_BUSY;
        fetch_req     = 1'b1;
        if (fetch_gnt) state_d = S_WAIT_FETCH;
      end
      S_WAIT_FETCH: begin
        proc_status_w = PS_BUSY;
        if (fetch_done) state_d = S_WRITE_MEM;
      end
      S_WRITE_MEM: begin
        proc_status_w = PS_BUSY;
        mem_wen       = 1'b1;
        if (mem_wready) begin
          pop     = 1'b1;
          acc_req = 1'b1;
          acc_cmd = CMD_DIRTY;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        proc_status_w = PS_DONE;
        state_d       = empty ? S_IDLE : S_LOOKUP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      tag_q   <= '0;
      fcmd_q  <= '0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
      fcmd_q  <= fcmd_d;
    end
  end

endmodule

// File: tb/tb_wr_buf_ctrl.sv
// Directed bench for wr_buf_ctrl: a per-cycle vector table for hit writes plus
// hand-written sequences for merge, miss/fetch, conflict, full and reset.
module tb_wr_buf_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        acc_wr_valid, acc_wr_ready;
  logic [31:0] acc_wr_addr, acc_wr_data;
  logic [3:0]  acc_wr_strb;
  logic        acc_req;
  logic [1:0]  acc_cmd;
  logic [31:0] acc_index;
  logic [2:0]  acc_status;
  logic [1:0]  return_tag;
  logic        allocate_busy;
  logic [2:0]  proc_status_w, proc_status_r;
  logic [31:0] proc_addr_w, proc_addr_r;
  logic        fetch_req, fetch_gnt, fetch_done;
  logic [1:0]  fetch_cmd, fetch_tag;
  logic [31:0] fetch_addr;
  logic        mem_wen, mem_wready;
  logic [6:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        wb_empty;

  logic [2:0]  lk_st, al_st;
  logic [1:0]  rtag;
  int          n_chk = 0;
  int          n_fail = 0;
  int          wr_acc = 0;
  int          wen_seen = 0;

  always #5 clk = ~clk;

  // Tag-array responder: answers in the same cycle as the command strobe.
  assign acc_status = (acc_req && acc_cmd == 2'b00) ? lk_st :
                      (acc_req && acc_cmd == 2'b10) ? al_st : 3'b000;
  assign return_tag = rtag;

  always @(posedge clk) begin
    if (mem_wen && mem_wready) wr_acc <= wr_acc + 1;
    if (mem_wen) wen_seen <= wen_seen + 1;
  end

  wr_buf_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .acc_wr_valid(acc_wr_valid), .acc_wr_ready(acc_wr_ready),
    .acc_wr_addr(acc_wr_addr), .acc_wr_data(acc_wr_data), .acc_wr_strb(acc_wr_strb),
    .acc_req(acc_req), .acc_cmd(acc_cmd), .acc_index(acc_index),
    .acc_status(acc_status), .return_tag(return_tag), .allocate_busy(allocate_busy),
    .proc_status_w(proc_status_w), .proc_addr_w(proc_addr_w),
    .proc_status_r(proc_status_r), .proc_addr_r(proc_addr_r),
    .fetch_req(fetch_req), .fetch_gnt(fetch_gnt), .fetch_done(fetch_done),
    .fetch_cmd(fetch_cmd), .fetch_tag(fetch_tag), .fetch_addr(fetch_addr),
    .mem_wen(mem_wen), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_wready(mem_wready), .wb_empty(wb_empty)
  );

  typedef struct {
    logic        wv;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [2:0]  lk;
    logic [1:0]  tag;
    logic        e_rdy;
    logic        e_req;
    logic [1:0]  e_cmd;
    logic        e_wen;
    logic [6:0]  e_waddr;
    logic [31:0] e_wdata;
    logic [3:0]  e_wstrb;
    logic [2:0]  e_ps;
    logic        e_empty;
  } vec_t;

  vec_t tbl [12];

  function automatic vec_t mk(input logic wv, input logic [31:0] addr, data,
                              input logic [3:0] strb, input logic [2:0] lk,
                              input logic [1:0] tag, input logic e_req,
                              input logic [1:0] e_cmd, input logic e_wen,
                              input logic [6:0] e_waddr, input logic [31:0] e_wdata,
                              input logic [3:0] e_wstrb, input logic [2:0] e_ps,
                              input logic e_empty);
    vec_t v;
    v.wv = wv; v.addr = addr; v.data = data; v.strb = strb; v.lk = lk; v.tag = tag;
    v.e_rdy = 1'b1; v.e_req = e_req; v.e_cmd = e_cmd; v.e_wen = e_wen;
    v.e_waddr = e_waddr; v.e_wdata = e_wdata; v.e_wstrb = e_wstrb;
    v.e_ps = e_ps; v.e_empty = e_empty;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic put(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    acc_wr_valid = 1'b1; acc_wr_addr = a; acc_wr_data = d; acc_wr_strb = s;
  endtask

  task automatic wait_empty(input string name, input int budget);
    bit ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (wb_empty) begin ok = 1'b1; break; end
      step();
    end
    chk(name, ok, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  base;
    bit  ok;
    acc_wr_valid = 0; acc_wr_addr = 0; acc_wr_data = 0; acc_wr_strb = 0;
    allocate_busy = 0; proc_status_r = 0; proc_addr_r = 0;
    fetch_gnt = 0; fetch_done = 0; mem_wready = 1;
    lk_st = 0; al_st = 0; rtag = 0;

    //            wv  addr      data          strb lk  tag req cmd wen waddr  wdata         wstrb ps  empty
    tbl[0]  = mk(1, 32'h100, 32'hA5A5A5A5, 4'hF, 0, 0, 0, 0, 0, 7'h00, 32'h0,        4'h0, 0, 1);
    tbl[1]  = mk(0, 32'h0,   32'h0,        4'h0, 0, 0, 0, 0, 0, 7'h00, 32'h0,        4'h0, 0, 0);
    tbl[2]  = mk(0, 32'h0,   32'h0,        4'h0, 1, 2, 1, 0, 0, 7'h00, 32'h0,        4'h0, 0, 0);
    tbl[3]  = mk(0, 32'h0,   32'h0,        4'h0, 0, 0, 1, 3, 1, 7'h40, 32'hA5A5A5A5, 4'hF, 2, 0);
    tbl[4]  = mk(0, 32'h0,   32'h0,        4'h0, 0, 0, 0, 0, 0, 7'h00, 32'h0,        4'h0, 3, 0);
    tbl[5]  = mk(0, 32'h0,   32'h0,        4'h0, 0, 0, 0, 0, 0, 7'h00, 32'h0,        4'h0, 0, 1);
    tbl[6]  = mk(1, 32'h204, 32'h12345678, 4'h5, 0, 0, 0, 0, 0, 7'h00, 32'h0,        4'h0, 0, 1);
    tbl[7]  = mk(0, 32'h0,   32'h0,        4'h0, 0, 0, 0, 0, 0, 7'h00, 32'h0,        4'h0, 0, 0);
    tbl[8]  = mk(0, 32'h0,   32'h0,        4'h0, 2, 1, 1, 0, 0, 7'h00, 32'h0,        4'h0, 0, 0);
    tbl[9]  = mk(0, 32'h0,   32'h0,        4'h0, 0, 0, 1, 3, 1, 7'h21, 32'h12345678, 4'h5, 2, 0);
    tbl[10] = mk(0, 32'h0,   32'h0,        4'h0, 0, 0, 0, 0, 0, 7'h00, 32'h0,        4'h0, 3, 0);
    tbl[11] = mk(0, 32'h0,   32'h0,        4'h0, 0, 0, 0, 0, 0, 7'h00, 32'h0,        4'h0, 0, 1);

    // Reset state, sampled while reset is held
    #12;
    chk("rst_ready", acc_wr_ready, 1);
    chk("rst_wb_empty", wb_empty, 1);
    chk("rst_outs", {acc_req, acc_cmd, fetch_req, fetch_cmd, fetch_tag, mem_wen, mem_wstrb, proc_status_w}, 0);
    chk("rst_addrs", {acc_index, fetch_addr, proc_addr_w}, 0);
    chk("rst_mem", {mem_waddr, mem_wdata}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Hit writes: per-cycle vector table
    for (int i = 0; i < 12; i++) begin
      acc_wr_valid = tbl[i].wv; acc_wr_addr = tbl[i].addr;
      acc_wr_data = tbl[i].data; acc_wr_strb = tbl[i].strb;
      lk_st = tbl[i].lk; rtag = tbl[i].tag;
      #1;
      chk($sformatf("v%0d_ready", i), acc_wr_ready, tbl[i].e_rdy);
      chk($sformatf("v%0d_acc_req", i), acc_req, tbl[i].e_req);
      chk($sformatf("v%0d_acc_cmd", i), acc_cmd, tbl[i].e_cmd);
      chk($sformatf("v%0d_mem_wen", i), mem_wen, tbl[i].e_wen);
      chk($sformatf("v%0d_waddr", i), mem_waddr, tbl[i].e_waddr);
      chk($sformatf("v%0d_wdata", i), mem_wdata, tbl[i].e_wdata);
      chk($sformatf("v%0d_wstrb", i), mem_wstrb, tbl[i].e_wstrb);
      chk($sformatf("v%0d_proc_status", i), proc_status_w, tbl[i].e_ps);
      chk($sformatf("v%0d_wb_empty", i), wb_empty, tbl[i].e_empty);
      step();
    end
    acc_wr_valid = 0;

    // Merge: two partial writes to 0x104 while 0x100 stalls in the data array
    lk_st = 3'b001; rtag = 2'd3; mem_wready = 0;
    put(32'h100, 32'hDEADBEEF, 4'hF); step();
    put(32'h104, 32'h00001111, 4'h3); step();
    put(32'h104, 32'h22220000, 4'hC); #1;
    chk("merge_ready", acc_wr_ready, 1);
    step();
    acc_wr_valid = 0; #1;
    chk("stall_wen", mem_wen, 1);
    chk("stall_waddr", mem_waddr, 7'h60);
    chk("stall_wdata", mem_wdata, 32'hDEADBEEF);
    step();
    chk("stall_hold_wen", mem_wen, 1);
    base = wr_acc;
    mem_wready = 1;
    step(); step(); step(); #1;
    chk("merge_wen", mem_wen, 1);
    chk("merge_waddr", mem_waddr, 7'h61);
    chk("merge_wdata", mem_wdata, 32'h22221111);
    chk("merge_wstrb", mem_wstrb, 4'hF);
    step(); step();
    chk("merge_drained", wb_empty, 1);
    chk("merge_write_count", wr_acc - base, 2);

    // Miss with a dirty victim, allocator busy for one cycle, delayed grant
    lk_st = 3'b000; al_st = 3'b010; rtag = 2'd1;
    put(32'h300, 32'hCAFEF00D, 4'hF); step();
    acc_wr_valid = 0; step(); #1;
    chk("miss_lookup_req", {acc_req, acc_cmd}, 3'b100);
    chk("miss_index", acc_index, 32'h300);
    step(); #1;
    chk("miss_check_ps", proc_status_w, 3'b001);
    allocate_busy = 1; step(); #1;
    chk("alloc_busy_ps", proc_status_w, 3'b010);
    chk("alloc_busy_noreq", acc_req, 0);
    allocate_busy = 0; #1;
    chk("alloc_cmd", {acc_req, acc_cmd}, 3'b110);
    step(); #1;
    chk("fetch_req_1", fetch_req, 1);
    chk("fetch_cmd_wb", fetch_cmd, 2'b10);
    chk("fetch_tag", fetch_tag, 2'd1);
    chk("fetch_addr", fetch_addr, 32'h300);
    step(); #1;
    chk("fetch_req_2", fetch_req, 1);
    fetch_gnt = 1; step();
    fetch_gnt = 0; #1;
    chk("wait_fetch_noreq", fetch_req, 0);
    chk("wait_fetch_nowen", mem_wen, 0);
    fetch_done = 1; step();
    fetch_done = 0; #1;
    chk("miss_wen", mem_wen, 1);
    chk("miss_waddr", mem_waddr, 7'h20);
    chk("miss_wdata", mem_wdata, 32'hCAFEF00D);
    wait_empty("miss_drain", 10);

    // Conflict: peer busy on the same line
    lk_st = 3'b000; proc_status_r = 3'b010; proc_addr_r = 32'h400;
    put(32'h404, 32'h0BADF00D, 4'hF); step();
    acc_wr_valid = 0; step(); step(); #1;
    chk("conf_check_ps", proc_status_w, 3'b001);
    chk("conf_proc_addr", proc_addr_w, 32'h400);
    step(); #1;
    chk("conf_wait_ps", proc_status_w, 3'b100);
    step(); #1;
    chk("conf_wait_hold", proc_status_w, 3'b100);
    proc_status_r = 3'b011; step(); #1;
    chk("conf_relookup", {acc_req, acc_cmd, proc_status_w}, 6'b100_000);
    lk_st = 3'b001; rtag = 2'd0; #1;
    proc_status_r = 3'b000;
    wait_empty("conf_drain", 10);

    // Full buffer: new word refused, same-word merge accepted
    mem_wready = 0; lk_st = 3'b001;
    put(32'h500, 32'h1, 4'hF); step();
    put(32'h504, 32'h2, 4'hF); step();
    put(32'h508, 32'h3, 4'hF); step();
    put(32'h50C, 32'h4, 4'hF); step();
    put(32'h510, 32'h5, 4'hF); #1;
    chk("full_new_word_ready", acc_wr_ready, 0);
    acc_wr_addr = 32'h50C; #1;
    chk("full_merge_ready", acc_wr_ready, 1);
    acc_wr_valid = 0;
    #1 rst_n = 0; #1;
    chk("full_rst_empty", wb_empty, 1);
    @(negedge clk);
    rst_n = 1;

    // Reset while a fetch is outstanding
    lk_st = 3'b000; al_st = 3'b001; rtag = 2'd2; mem_wready = 1;
    put(32'h600, 32'h77777777, 4'hF); step();
    acc_wr_valid = 0;
    ok = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (fetch_req) begin ok = 1'b1; break; end
      step();
    end
    chk("mf_fetch_seen", ok, 1);
    chk("mf_fetch_cmd", fetch_cmd, 2'b01);
    chk("mf_fetch_tag", fetch_tag, 2'd2);
    fetch_gnt = 1; step();
    fetch_gnt = 0;
    #2 rst_n = 0; #1;
    chk("mf_rst_empty", wb_empty, 1);
    chk("mf_rst_ready", acc_wr_ready, 1);
    chk("mf_rst_outs", {fetch_req, mem_wen, acc_req, proc_status_w, fetch_cmd}, 0);
    @(negedge clk);
    rst_n = 1;
    base = wen_seen;
    fetch_done = 1; step();
    fetch_done = 0;
    for (int k = 0; k < 5; k++) step();
    chk("mf_no_write", wen_seen - base, 0);
    chk("mf_idle_empty", wb_empty, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
